// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer: error-tagged UART receive buffer with first-word fall-through.
// Optional feature macro: UART_RX_TIMEOUT_EN (character-timeout counter).
// When the macro is undefined, timeout is tied to 0 and baud_pulse is ignored.
module uart_rx_buffer #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned TO_PULSES = 640
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     flush,
  input  logic                     baud_pulse,
  input  logic                     push,
  input  logic [DATA_W-1:0]        din,
  input  logic                     pe,
  input  logic                     fe,
  input  logic                     bi,
  input  logic                     pop,
  input  logic [1:0]               threshold,
  input  logic                     clr_oe,
  output logic [DATA_W-1:0]        dout,
  output logic                     dout_pe,
  output logic                     dout_fe,
  output logic                     dout_bi,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overrun,
  output logic                     fifo_err,
  output logic                     trig,
  output logic                     timeout
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = DATA_W + 3;

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_rptr;
  logic [AW-1:0] r_wptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_err_cnt;
  logic          r_en_q;
  logic          r_overrun;

  logic          w_clear;
  logic          w_empty;
  logic          w_full;
  logic          w_push_ok;
  logic          w_pop_ok;
  logic          w_drop;
  logic [EW-1:0] w_head;
  logic          w_head_err;
  logic          w_in_err;
  logic [CW-1:0] w_level;

  // Any toggle of FIFO mode discards contents, same as an explicit flush.
  assign w_clear    = flush | (en != r_en_q);
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == (en ? CW'(DEPTH) : CW'(1)));
  assign w_pop_ok   = pop & ~w_empty;
  assign w_push_ok  = push & (~w_full | pop);
  assign w_drop     = push & w_full & ~pop;
  assign w_head     = r_mem[r_rptr];
  assign w_head_err = |w_head[DATA_W+2:DATA_W];
  assign w_in_err   = pe | fe | bi;

  // Trigger level decode from the FCR threshold code.
  always_comb begin
    w_level = CW'(1);
    case (threshold)
      2'b00: w_level = CW'(1);
      2'b01: w_level = CW'(DEPTH / 4);
      2'b10: w_level = CW'(DEPTH / 2);
      2'b11: w_level = CW'(DEPTH - 2);
      default: w_level = CW'(1);
    endcase
  end

  // Storage write; contents past the read pointer are don't-care, so no reset.
  always_ff @(posedge clk) begin
    if (!w_clear && w_push_ok)
      r_mem[r_wptr] <= {bi, fe, pe, din};
  end

  // Pointers, occupancy, error-entry count and mode tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rptr    <= '0;
      r_wptr    <= '0;
      r_count   <= '0;
      r_err_cnt <= '0;
      r_en_q    <= en;
    end else begin
      r_en_q <= en;
      if (w_clear) begin
        r_rptr    <= '0;
        r_wptr    <= '0;
        r_count   <= '0;
        r_err_cnt <= '0;
      end else begin
        if (w_push_ok) r_wptr <= r_wptr + AW'(1);
        if (w_pop_ok)  r_rptr <= r_rptr + AW'(1);
        case ({w_push_ok, w_pop_ok})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
        case ({w_push_ok & w_in_err, w_pop_ok & w_head_err})
          2'b10:   r_err_cnt <= r_err_cnt + CW'(1);
          2'b01:   r_err_cnt <= r_err_cnt - CW'(1);
          default: r_err_cnt <= r_err_cnt;
        endcase
      end
    end
  end

  // Sticky overrun: a dropped character wins over a same-cycle clear request.
  always_ff @(posedge clk) begin
    if (rst)
      r_overrun <= 1'b0;
    else if (w_drop && !w_clear)
      r_overrun <= 1'b1;
    else if (clr_oe)
      r_overrun <= 1'b0;
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TO_PULSES + 1);
  logic [TW-1:0] r_to_cnt;

  // Character-timeout counter: restarts on any activity, saturates at the limit.
  always_ff @(posedge clk) begin
    if (rst || w_clear || w_push_ok || w_pop_ok || w_empty)
      r_to_cnt <= '0;
    else if (baud_pulse && (r_to_cnt != TW'(TO_PULSES)))
      r_to_cnt <= r_to_cnt + TW'(1);
  end

  assign timeout = ~w_empty & (r_to_cnt == TW'(TO_PULSES));
`else
  logic w_unused_baud;
  assign w_unused_baud = baud_pulse;
  assign timeout       = 1'b0;
`endif

  assign dout     = w_empty ? '0 : w_head[DATA_W-1:0];
  assign dout_pe  = ~w_empty & w_head[DATA_W];
  assign dout_fe  = ~w_empty & w_head[DATA_W+1];
  assign dout_bi  = ~w_empty & w_head[DATA_W+2];
  assign count    = r_count;
  assign empty    = w_empty;
  assign full     = w_full;
  assign overrun  = r_overrun;
  assign fifo_err = (r_err_cnt != '0);
  assign trig     = en ? (r_count >= w_level) : ~w_empty;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// tb_uart_rx_buffer: directed + random stimulus against a queue-based model.
module tb_uart_rx_buffer;

  localparam int DEPTH = 16;
  localparam int TOP   = 640;

  logic       clk = 1'b0;
  logic       rst, en, flush, baud_pulse, push, pe, fe, bi, pop, clr_oe;
  logic [7:0] din;
  logic [1:0] threshold;
  logic [7:0] dout;
  logic       dout_pe, dout_fe, dout_bi;
  logic [4:0] count;
  logic       empty, full, overrun, fifo_err, trig, timeout;

  uart_rx_buffer #(.DATA_W(8), .DEPTH(DEPTH), .TO_PULSES(TOP)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .baud_pulse(baud_pulse),
    .push(push), .din(din), .pe(pe), .fe(fe), .bi(bi), .pop(pop),
    .threshold(threshold), .clr_oe(clr_oe),
    .dout(dout), .dout_pe(dout_pe), .dout_fe(dout_fe), .dout_bi(dout_bi),
    .count(count), .empty(empty), .full(full), .overrun(overrun),
    .fifo_err(fifo_err), .trig(trig), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       bi;
  } ent_t;

  ent_t q[$];
  bit   m_ov;
  int   m_tc;
  bit   m_en_prev;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int level_of(input logic [1:0] t);
    case (t)
      2'd0: return 1;
      2'd1: return DEPTH / 4;
      2'd2: return DEPTH / 2;
      default: return DEPTH - 2;
    endcase
  endfunction

  task automatic check_all(input string tag);
    int   n;
    int   nerr;
    ent_t h;
    bit   exp_to;
    n    = q.size();
    nerr = 0;
    foreach (q[i]) if (q[i].pe || q[i].fe || q[i].bi) nerr++;
    h = (n > 0) ? q[0] : '0;
`ifdef UART_RX_TIMEOUT_EN
    exp_to = (n > 0) && (m_tc == TOP);
`else
    exp_to = 1'b0;
`endif
    chk({tag, ".dout"},     32'(dout),     32'(h.d));
    chk({tag, ".pe"},       32'(dout_pe),  32'(h.pe));
    chk({tag, ".fe"},       32'(dout_fe),  32'(h.fe));
    chk({tag, ".bi"},       32'(dout_bi),  32'(h.bi));
    chk({tag, ".count"},    32'(count),    32'(n));
    chk({tag, ".empty"},    32'(empty),    32'(n == 0));
    chk({tag, ".full"},     32'(full),     32'(n == (en ? DEPTH : 1)));
    chk({tag, ".overrun"},  32'(overrun),  32'(m_ov));
    chk({tag, ".fifo_err"}, 32'(fifo_err), 32'(nerr > 0));
    chk({tag, ".trig"},     32'(trig),     32'(en ? (n >= level_of(threshold)) : (n > 0)));
    chk({tag, ".timeout"},  32'(timeout),  32'(exp_to));
  endtask

  // One clock: apply inputs, advance the model on the edge, compare after it.
  task automatic step(input string tag, input bit i_push, input logic [7:0] d,
                      input logic [2:0] f, input bit i_pop, input bit i_flush,
                      input bit i_clr, input bit i_baud);
    bit   clr, was_full, pop_ok, push_ok, drop, was_empty;
    ent_t e;
    push = i_push; din = d; {bi, fe, pe} = f; pop = i_pop;
    flush = i_flush; clr_oe = i_clr; baud_pulse = i_baud;
    @(posedge clk);
    clr       = i_flush || (en != m_en_prev);
    m_en_prev = en;
    was_empty = (q.size() == 0);
    was_full  = (q.size() == (en ? DEPTH : 1));
    pop_ok    = i_pop && !was_empty;
    push_ok   = i_push && (!was_full || i_pop);
    drop      = i_push && was_full && !i_pop;
    if (!clr && drop) m_ov = 1'b1;
    else if (i_clr)   m_ov = 1'b0;
    if (clr) begin
      q.delete();
      m_tc = 0;
    end else begin
      if (push_ok || pop_ok || was_empty) m_tc = 0;
      else if (i_baud && m_tc < TOP)      m_tc++;
      if (pop_ok) void'(q.pop_front());
      if (push_ok) begin
        e.d = d; e.pe = f[0]; e.fe = f[1]; e.bi = f[2];
        q.push_back(e);
      end
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; flush = 1'b0; baud_pulse = 1'b0; push = 1'b0;
    din = '0; pe = 1'b0; fe = 1'b0; bi = 1'b0; pop = 1'b0;
    threshold = 2'b00; clr_oe = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete(); m_ov = 1'b0; m_tc = 0; m_en_prev = en;
    check_all("reset");

    // Single flagged character, then pop.
    step("push_a5", 1, 8'hA5, 3'b001, 0, 0, 0, 0);
    chk("a5_head", 32'(dout), 32'hA5);
    step("pop_a5", 0, 8'h00, 3'b000, 1, 0, 0, 0);

    // Trigger at DEPTH/2, fill, overflow.
    threshold = 2'b10;
    for (int i = 0; i < 7; i++) step("fill7", 1, 8'(i + 1), 3'b000, 0, 0, 0, 0);
    chk("trig_at7", 32'(trig), 32'd0);
    step("fill8", 1, 8'h08, 3'b000, 0, 0, 0, 0);
    chk("trig_at8", 32'(trig), 32'd1);
    for (int i = 8; i < 16; i++) step("fill16", 1, 8'(i + 1), 3'b010, 0, 0, 0, 0);
    chk("full_16", 32'(full), 32'd1);
    step("ovf_3c", 1, 8'h3C, 3'b000, 0, 0, 0, 0);
    chk("ovf_flag", 32'(overrun), 32'd1);
    chk("ovf_head", 32'(dout), 32'h01);
    step("clr_oe", 0, 8'h00, 3'b000, 0, 0, 1, 0);

    // Push+pop while full, drain to the new character.
    step("full_pp", 1, 8'h11, 3'b100, 1, 0, 0, 0);
    chk("full_pp_cnt", 32'(count), 32'd16);
    for (int i = 0; i < 15; i++) step("drain", 0, 8'h00, 3'b000, 1, 0, 0, 0);
    chk("head_11", 32'(dout), 32'h11);
    step("drain_last", 0, 8'h00, 3'b000, 1, 0, 0, 0);

    // Holding-register mode.
    en = 1'b0;
    step("en_off", 0, 8'h00, 3'b000, 0, 0, 0, 0);
    step("hr_55", 1, 8'h55, 3'b000, 0, 0, 0, 0);
    chk("hr_full", 32'(full), 32'd1);
    step("hr_66", 1, 8'h66, 3'b000, 0, 0, 0, 0);
    chk("hr_keep55", 32'(dout), 32'h55);
    en = 1'b1;
    step("en_on", 0, 8'h00, 3'b000, 0, 0, 1, 0);
    chk("en_on_empty", 32'(empty), 32'd1);

    // Character timeout.
    step("to_push", 1, 8'h77, 3'b000, 0, 0, 0, 0);
    for (int i = 0; i < TOP - 1; i++) step("to_wait", 0, 8'h00, 3'b000, 0, 0, 0, 1);
    chk("to_639", 32'(timeout), 32'd0);
    step("to_640", 0, 8'h00, 3'b000, 0, 0, 0, 1);
`ifdef UART_RX_TIMEOUT_EN
    chk("to_fire", 32'(timeout), 32'd1);
`endif
    step("to_pop", 0, 8'h00, 3'b000, 1, 0, 0, 1);
    chk("to_clear", 32'(timeout), 32'd0);

    // Flush with a simultaneous push; overrun left as is.
    step("ovf_setup", 1, 8'h01, 3'b000, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("pre_flush", 1, 8'(8'hE0 + i), 3'b001, 0, 0, 0, 0);
    step("flush_push", 1, 8'h99, 3'b000, 0, 1, 0, 0);
    chk("flush_empty", 32'(empty), 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) en = ~en;
      if ($urandom_range(0, 19) == 0) threshold = 2'($urandom_range(0, 3));
      step("rand", $urandom_range(0, 1) == 1, 8'($urandom), 3'($urandom_range(0, 7)) & 3'($urandom),
           $urandom_range(0, 9) < 4, $urandom_range(0, 39) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_buffer.md
# uart_rx_buffer

Parametrised receive buffer for the UART16550 datapath, placed between the RX deserializer and the register file. It replaces the generic receive FIFO with a depth-configurable, error-tagged buffer. It adds FCR trigger-level decoding, a 16450 single-character mode, sticky overrun, an LSR-bit-7 style error summary, and a character-timeout interrupt source.

## Interface
Parameters:
- DATA_W, 8, character width stored per entry
- DEPTH, 16, entries; power of two, ≥4
- TO_PULSES, 640, baud_pulse count with no push/pop before timeout fires (4 chars × 10 bits × 16)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- en  in  1  FIFO mode (FCR0); 0 = single-entry holding-register mode
- flush  in  1  synchronous clear of contents (FCR1 / rx_rst)
- baud_pulse  in  1  baud-rate tick for timeout counting
- push  in  1  write request from RX
- din  in  DATA_W  received character
- pe, fe, bi  in  1 each  error flags of the character on din
- pop  in  1  read request (RBR read)
- threshold  in  2  trigger code: 00→1, 01→DEPTH/4, 10→DEPTH/2, 11→DEPTH-2
- clr_oe  in  1  clears overrun (LSR read)
- dout  out  DATA_W  head character; 0 when empty
- dout_pe, dout_fe, dout_bi  out  1 each  flags of head entry; 0 when empty
- count  out  $clog2(DEPTH)+1  occupancy
- empty  out  1  count==0
- full  out  1  count==effective depth
- overrun  out  1  sticky overrun error
- fifo_err  out  1  ≥1 stored entry has any flag set
- trig  out  1  count ≥ decoded trigger level
- timeout  out  1  character-timeout indication

## Operation
- Storage: DEPTH × (DATA_W+3) array; read pointer, write pointer and count are registered. Pointers wrap modulo DEPTH.
- Effective depth: DEPTH when en=1, 1 when en=0. In en=0 mode, trig = !empty.
- Priority: rst > flush > en change > push/pop.
- Any edge of en (en ≠ registered copy) clears contents like flush.
- Push accepted when !full, or when full with a pop in the same cycle. Accepted push+pop leaves count unchanged and advances both pointers.
- Push when full without pop: character dropped, pointers unchanged, overrun set.
- Pop when empty: ignored. Push+pop when empty: push accepted, pop ignored, count→1.
- overrun: set on dropped push; cleared by clr_oe. Set wins over simultaneous clr_oe. flush does not clear it; rst does.
- fifo_err: internal err_cnt, 0..DEPTH. Increments on an accepted push with (pe|fe|bi). Decrements on an accepted pop whose head has any flag. Both in the same cycle → unchanged. Cleared by flush, en change and rst.
- Trigger: level decoded combinationally from threshold; trig = count ≥ level (en=1).
- Timeout counter: cleared on accepted push, accepted pop, flush, en change, and while empty. Otherwise increments on baud_pulse and saturates at TO_PULSES. timeout=1 while !empty and counter==TO_PULSES; it stays high until the next push/pop/flush.

## Timing
- Reset values: count=0, empty=1, full=0, dout=0, all flag outputs 0, overrun=0, fifo_err=0, trig=0, timeout=0.
- First-word fall-through: dout/flags reflect the head combinationally from the registered read pointer.
- A character pushed in cycle N is visible on dout in N+1 if the buffer was empty.
- Pop in cycle N: next entry appears in N+1.
- count, empty, full, overrun, fifo_err, timeout are registered; they update the cycle after the causing event.
- trig is combinational from registered count and threshold.
- flush/rst in cycle N: empty=1 in N+1. A push in the same cycle as flush is discarded.

## Configuration
- UART_RX_TIMEOUT_EN defined: timeout counter and timeout output logic are present, as described above.
- Undefined: no counter is synthesised, timeout is tied to 0, and baud_pulse is unused.

## Test plan
- Reset, en=1: push 0xA5 with pe=1 → next cycle dout=0xA5, dout_pe=1, count=1, fifo_err=1. Pop → empty=1, fifo_err=0.
- threshold=10, DEPTH=16: push 7 chars → trig=0; 8th push → trig=1. Push to 16 → full=1. 17th push 0x3C → dropped, overrun=1, head unchanged. clr_oe → overrun=0.
- Full buffer, simultaneous push 0x11 and pop → count stays 16, overrun=0. After 15 more pops, dout=0x11.
- en=0: push 0x55 → full=1, trig=1. Push 0x66 → overrun=1, dout=0x55. Toggle en → empty=1, count=0.
- UART_RX_TIMEOUT_EN, TO_PULSES=640: push 1 char, then 639 baud_pulses → timeout=0. 640th → timeout=1. Pop → timeout=0 next cycle.
- Push 3 chars then flush together with a push → empty=1, fifo_err=0, overrun unchanged, pushed char discarded.
